// File: rtl/display_arbiter.sv
// display_arbiter: round-robin sharing of the 4-digit seven-segment driver
// between four requesters, with a programmable minimum dwell per grant.
module display_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [15:0]     val0,
  input  logic [15:0]     val1,
  input  logic [15:0]     val2,
  input  logic [15:0]     val3,
  input  logic [DW-1:0]   dwell,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      src_id,
  output logic [15:0]     digit,
  output logic            busy
);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      src_q, src_d;
  logic [15:0]     digit_q, digit_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [1:0]      ptr_q, ptr_d;
  logic            live_q, live_d;

  logic [1:0]      win;
  logic [15:0]     win_val;
  logic [15:0]     cur_val;
  logic            sole_owner;
  logic            do_grant;

  function automatic logic [15:0] pick_val(input logic [1:0] idx,
                                           input logic [15:0] v0,
                                           input logic [15:0] v1,
                                           input logic [15:0] v2,
                                           input logic [15:0] v3);
    logic [15:0] r;
    unique case (idx)
      2'd0:    r = v0;
      2'd1:    r = v1;
      2'd2:    r = v2;
      default: r = v3;
    endcase
    return r;
  endfunction

  // Round-robin winner: first set request at or above ptr, wrapping 3->0.
  always_comb begin
    win = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
    end
  end

  // Source values for the candidate winner and the current owner.
  always_comb begin
    win_val    = pick_val(win, val0, val1, val2, val3);
    cur_val    = pick_val(src_q, val0, val1, val2, val3);
    sole_owner = ((req & ~(NREQ'(1) << src_q)) == '0);
  end

  // State register: every output and tenure field lives here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      src_q   <= '0;
      digit_q <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      src_q   <= src_d;
      digit_q <= digit_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      live_q  <= live_d;
    end
  end

  // Next-state logic: dwell countdown, tracking, early drop and (re)grant.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    src_d    = src_q;
    digit_d  = digit_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    live_d   = live_q;
    do_grant = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) do_grant = 1'b1;
      end
      SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DW'(1);
          if (live_q && req[src_q]) begin
            digit_d = cur_val;
          end else if (!req[src_q]) begin
            gnt_d  = '0;
            live_d = 1'b0;
          end
        end else if (live_q && req[src_q] && sole_owner) begin
          digit_d = cur_val;
        end else if (|req) begin
          do_grant = 1'b1;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          live_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      gnt_d   = NREQ'(1) << win;
      src_d   = win;
      digit_d = win_val;
      cnt_d   = (dwell == '0) ? '0 : dwell - DW'(1);
      ptr_d   = win + 2'd1;
      live_d  = 1'b1;
      state_d = SHOW;
      busy_d  = 1'b1;
    end
  end

  // Outputs come straight from registers, so nothing is combinational from inputs.
  always_comb begin
    gnt    = gnt_q;
    src_id = src_q;
    digit  = digit_q;
    busy   = busy_q;
  end

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a tenure-level model.
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'h0;
  logic [15:0] val0 = 16'h0, val1 = 16'h0, val2 = 16'h0, val3 = 16'h0;
  logic [15:0] dwell = 16'h0;
  logic [3:0]  gnt;
  logic [1:0]  src_id;
  logic [15:0] digit;
  logic        busy;

  int checks = 0;
  int failures = 0;

  // Model state: owner, edges elapsed since the grant and the dwell length.
  bit          m_show = 1'b0;
  int          m_owner = 0;
  logic [3:0]  m_gnt = 4'h0;
  logic [15:0] m_digit = 16'h0;
  bit          m_busy = 1'b0;
  int          m_ptr = 0;
  bit          m_alive = 1'b0;
  int          m_elapsed = 0;
  int          m_len = 1;

  display_arbiter #(.NREQ(4), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .dwell(dwell), .gnt(gnt), .src_id(src_id), .digit(digit), .busy(busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] d,
                               input logic [15:0] v0, input logic [15:0] v1,
                               input logic [15:0] v2, input logic [15:0] v3);
    req   = r;
    dwell = d;
    val0  = v0;
    val1  = v1;
    val2  = v2;
    val3  = v3;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic doReset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] valOf(input int i);
    case (i)
      0:       return val0;
      1:       return val1;
      2:       return val2;
      default: return val3;
    endcase
  endfunction

  // Behavioural model: a tenure lasts max(dwell,1) edges, then the owner is
  // kept only if it is alone and still live; otherwise rotate from owner+1.
  always @(posedge clk or negedge rst_n) begin : model
    bit          show, alive, busy_n, grant;
    int          owner, ptr, elapsed, len, w;
    logic [3:0]  g;
    logic [15:0] dg;
    if (!rst_n) begin
      m_show    <= 1'b0;
      m_owner   <= 0;
      m_gnt     <= 4'h0;
      m_digit   <= 16'h0;
      m_busy    <= 1'b0;
      m_ptr     <= 0;
      m_alive   <= 1'b0;
      m_elapsed <= 0;
      m_len     <= 1;
    end else begin
      show = m_show; alive = m_alive; busy_n = m_busy; owner = m_owner;
      ptr = m_ptr; elapsed = m_elapsed; len = m_len; g = m_gnt; dg = m_digit;
      grant = 1'b0;
      if (!show) begin
        grant = (req != 4'h0);
      end else begin
        elapsed++;
        if (elapsed < len) begin
          if (alive && req[owner]) dg = valOf(owner);
          else if (!req[owner]) begin alive = 1'b0; g = 4'h0; end
        end else if (alive && req == (4'b0001 << owner)) begin
          dg = valOf(owner);
        end else if (req != 4'h0) begin
          grant = 1'b1;
        end else begin
          show = 1'b0; g = 4'h0; busy_n = 1'b0; alive = 1'b0;
        end
      end
      if (grant) begin
        w = -1;
        for (int k = 0; k < 4; k++)
          if (w < 0 && req[(ptr + k) % 4]) w = (ptr + k) % 4;
        owner = w; g = 4'b0001 << w; dg = valOf(w);
        len = (dwell == 16'h0) ? 1 : int'(dwell);
        elapsed = 0; ptr = (w + 1) % 4;
        alive = 1'b1; show = 1'b1; busy_n = 1'b1;
      end
      m_show <= show; m_alive <= alive; m_busy <= busy_n; m_owner <= owner;
      m_ptr <= ptr; m_elapsed <= elapsed; m_len <= len; m_gnt <= g;
      m_digit <= dg;
    end
  end

  // Compare every output against the model halfway through each cycle.
  always @(negedge clk) begin
    checkOutput("model_gnt", 32'(gnt), 32'(m_gnt));
    checkOutput("model_src_id", 32'(src_id), 32'(m_owner[1:0]));
    checkOutput("model_digit", 32'(digit), 32'(m_digit));
    checkOutput("model_busy", 32'(busy), 32'(m_busy));
  end

  initial begin
    logic [3:0] exp_g;

    // Reset held with all requests up.
    req = 4'hF;
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", 32'(gnt), 32'h0);
    checkOutput("rst_digit", 32'(digit), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    applyStimulus(4'hF, 16'd3, 16'h1234, 16'h0, 16'h0, 16'h0);
    rst_n = 1'b1;
    tick();
    checkOutput("first_gnt", 32'(gnt), 32'h1);
    checkOutput("first_digit", 32'(digit), 32'h1234);
    checkOutput("first_src", 32'(src_id), 32'h0);

    // Dwell 4 and rotation between requesters 0 and 2.
    doReset();
    applyStimulus(4'b0101, 16'd4, 16'hAAAA, 16'h0, 16'hBBBB, 16'h0);
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_g = (i < 4) ? 4'b0001 : (i < 8) ? 4'b0100 : 4'b0001;
      checkOutput($sformatf("rot_gnt_%0d", i), 32'(gnt), 32'(exp_g));
    end
    checkOutput("rot_digit", 32'(digit), 32'hAAAA);

    // Early drop: gnt falls, digit freezes, busy lasts the full dwell.
    doReset();
    applyStimulus(4'b0010, 16'd10, 16'h0, 16'h00C5, 16'h0, 16'h0);
    tick();
    checkOutput("drop_gnt_on", 32'(gnt), 32'h2);
    tick();
    req = 4'b0000;
    val1 = 16'hFFFF;
    tick();
    checkOutput("drop_gnt_off", 32'(gnt), 32'h0);
    checkOutput("drop_digit", 32'(digit), 32'h00C5);
    req = 4'b0010;
    repeat (7) tick();
    checkOutput("drop_no_revive", 32'(gnt), 32'h0);
    checkOutput("drop_busy_hold", 32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    checkOutput("drop_busy_end", 32'(busy), 32'h0);
    checkOutput("drop_digit_idle", 32'(digit), 32'h00C5);

    // Tracking and sole ownership past the dwell.
    doReset();
    applyStimulus(4'b1000, 16'd2, 16'h0, 16'h0, 16'h0, 16'h0001);
    tick();
    checkOutput("trk_gnt", 32'(gnt), 32'h8);
    repeat (4) tick();
    val3 = 16'h0002;
    tick();
    checkOutput("trk_digit", 32'(digit), 32'h0002);
    repeat (5) tick();
    checkOutput("trk_hold", 32'(gnt), 32'h8);
    req = 4'b1001;
    tick();
    checkOutput("trk_handoff", 32'(gnt), 32'h1);

    // Dwell 0 behaves as one cycle per tenure.
    doReset();
    applyStimulus(4'b0011, 16'd0, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("dw0_gnt_%0d", i), 32'(gnt),
                  (i % 2 == 0) ? 32'h1 : 32'h2);
    end

    // Asynchronous reset in the middle of a tenure.
    doReset();
    applyStimulus(4'b0100, 16'd8, 16'h0, 16'h0, 16'h5A5A, 16'h0);
    repeat (2) tick();
    checkOutput("ar_gnt_pre", 32'(gnt), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_gnt", 32'(gnt), 32'h0);
    checkOutput("ar_digit", 32'(digit), 32'h0);
    checkOutput("ar_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0110;
    tick();
    checkOutput("ar_restart", 32'(gnt), 32'h2);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 5) == 0) val0 = 16'($urandom);
      if ($urandom_range(0, 5) == 0) val1 = 16'($urandom);
      if ($urandom_range(0, 5) == 0) val2 = 16'($urandom);
      if ($urandom_range(0, 5) == 0) val3 = 16'($urandom);
      dwell = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
